pc_fetch_unit: RTL

- Parametrised program-counter unit for the RISC-V core.
- Supersedes the plain 32-bit PC register. Adds:
  - a configurable reset vector
  - auto-increment
  - stall, redirect and flush control
  - a halt/resume state machine
  - an IF/ID pipeline register carrying pc and pc+4 with a valid bit
- Sits between the instruction memory address port and the decode stage.

---
 rtl/pc_fetch_unit_pkg.sv | 14 +
 rtl/pc_fetch_unit_pipe_reg.sv | 25 ++
 rtl/pc_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and default constants for the program-counter fetch unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int unsigned PC_INSTR_BYTES = 4;
  localparam logic [31:0] PC_RESET_VEC   = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VEC    = 32'h0000_0100;

endpackage

// File: rtl/pc_fetch_unit_pipe_reg.sv
// Generic pipeline register with synchronous reset, synchronous clear and enable.
module pipe_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with boot/run/halt control and IF/ID register.
// Define PC_MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VEC.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VEC),
  parameter int unsigned     INSTR_BYTES = PC_INSTR_BYTES,
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(PC_TRAP_VEC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            flush,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic            ifid_valid,
  output logic            halted,
  output logic            misalign_trap
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus, redir_pc;
  logic            trap_q, trap_d, redir_trap;
  logic            ifid_en, ifid_clr;
  logic [2*XLEN:0] ifid_d, ifid_q;

  assign pc_plus = pc_q + STEP;

  // With trapping disabled, the misalign test is constant-false and the
  // target is simply aligned down; aligned targets pass unchanged either way.
  assign redir_trap = TRAP_EN && ((redirect_target & LOW_MASK) != '0);
  assign redir_pc   = redir_trap ? TRAP_VEC : (redirect_target & ~LOW_MASK);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    trap_d   = 1'b0;
    ifid_en  = 1'b0;
    ifid_clr = flush;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          pc_d     = redir_pc;
          trap_d   = redir_trap;
          ifid_clr = 1'b1;
        end else begin
          if (!stall) begin
            pc_d    = pc_plus;
            ifid_en = 1'b1;
          end
          if (halt_req) begin
            state_d  = HALT;
            ifid_clr = 1'b1;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d     = redir_pc;
          trap_d   = redir_trap;
          ifid_clr = 1'b1;
        end
        if (resume) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      trap_q  <= trap_d;
    end
  end

  assign pc_valid = (state_q == RUN);
  assign ifid_d   = {pc_q, pc_plus, pc_valid};

  pipe_reg #(
    .WIDTH(2 * XLEN + 1)
  ) u_ifid (
    .clk_i(clk),
    .rst_i(rst),
    .clr_i(ifid_clr),
    .en_i (ifid_en),
    .d_i  (ifid_d),
    .q_o  (ifid_q)
  );

  assign pc_out        = pc_q;
  assign halted        = (state_q == HALT);
  assign misalign_trap = trap_q;
  assign ifid_pc       = ifid_q[2*XLEN:XLEN+1];
  assign ifid_pc_plus4 = ifid_q[XLEN:1];
  assign ifid_valid    = ifid_q[0];

endmodule
